// File: rtl/encoder83_pending_if.sv
// ---------------------------------------------------------------------------
// encoder83_pending_if
//   Valid/ready handshake that carries one encoded line index from the
//   pending-request encoder to its consumer.
//
//   code  : 3-bit index of the granted line (driven by master)
//   valid : code is valid this cycle (driven by master)
//   ready : consumer accepts code when valid && ready (driven by slave)
//
//   master : the encoder side
//   slave  : the consumer side
// ---------------------------------------------------------------------------
interface encoder83_pending_if;
  logic [2:0] code;
  logic       valid;
  logic       ready;

  modport master (output code, output valid, input ready);
  modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/encoder83_pending.sv
// ---------------------------------------------------------------------------
// encoder83_pending
//   Sequential 8-to-3 encoder. Single-cycle request pulses on eight lines
//   are collected in a pending register. One pending line at a time is
//   offered as a 3-bit index over a valid/ready handshake, and that line is
//   cleared when the consumer accepts it.
//
//   Parameter RR : 0 = fixed priority, highest index wins
//                  1 = round-robin, ascending search from last_grant+1
//
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   E        : issue enable; 0 stops a new code from being loaded
//   req      : request pulses, bit i = event on line i
//   clr      : synchronous clear of pending and output state
//   bus      : handshake (code/valid out, ready in)
//   pending  : pending-request register
//   overflow : one-cycle pulse, a req hit a bit that was already pending
//              and was not being accepted in the same cycle
// ---------------------------------------------------------------------------
module encoder83_pending #(
  parameter bit RR = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        E,
  input  logic [7:0]                  req,
  input  logic                        clr,
  encoder83_pending_if.master         bus,
  output logic [7:0]                  pending,
  output logic                        overflow
);

  logic       accept;
  logic [7:0] acc_oh;
  logic [7:0] sel_src;
  logic [2:0] last_grant;
  logic [2:0] lg_eff;
  logic [2:0] probe;
  logic [2:0] sel_idx;

  assign accept  = bus.valid && bus.ready;
  assign acc_oh  = accept ? (8'b1 << bus.code) : 8'h00;
  // The line being accepted this cycle is not eligible for re-selection,
  // even if a fresh req for it arrives now; that req only becomes eligible
  // once it is visible in the register.
  assign sel_src = pending & ~acc_oh;

  // NOTE: every variable written in this always_comb gets a default first,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    sel_idx = 3'd0;
    probe   = 3'd0;
    // Round-robin pointer reflects an accept happening in this same cycle.
    lg_eff  = accept ? bus.code : last_grant;
    if (RR == 1'b0) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < 8; i++) begin
        if (sel_src[i]) sel_idx = 3'(i);
      end
    end else begin
      // Descending offset scan: the last hit is the nearest set bit above
      // lg_eff, with 3-bit arithmetic providing the 7->0 wrap.
      for (int i = 7; i >= 0; i--) begin
        probe = lg_eff + 3'(i) + 3'd1;
        if (sel_src[probe]) sel_idx = probe;
      end
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 8'h00;
      overflow   <= 1'b0;
      bus.code   <= 3'd0;
      bus.valid  <= 1'b0;
      last_grant <= 3'd7;
    end else if (clr) begin
      // last_grant survives a clear so round-robin fairness is preserved.
      pending   <= 8'h00;
      overflow  <= 1'b0;
      bus.code  <= 3'd0;
      bus.valid <= 1'b0;
    end else begin
      pending  <= sel_src | req;
      overflow <= |(req & sel_src);
      if (accept) last_grant <= bus.code;
      // An offered code is held until accepted; an accept cycle may reload
      // directly so back-to-back grants have no bubble.
      if (!bus.valid || accept) begin
        if (E && (sel_src != 8'h00)) begin
          bus.code  <= sel_idx;
          bus.valid <= 1'b1;
        end else begin
          bus.valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder83_pending.sv
// ---------------------------------------------------------------------------
// tb_encoder83_pending
//   Directed bench for encoder83_pending. Two instances share E/req/clr/rst_n:
//   dut_fp (fixed priority) and dut_rr (round-robin), each with its own
//   handshake interface. Inputs change and outputs are sampled 1 ns after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_encoder83_pending;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic [7:0] req;
  logic       clr;
  logic [7:0] pending_fp, pending_rr;
  logic       overflow_fp, overflow_rr;

  int total;
  int bad;

  encoder83_pending_if bus_fp ();
  encoder83_pending_if bus_rr ();

  encoder83_pending #(.RR(1'b0)) dut_fp (
    .clk      (clk),
    .rst_n    (rst_n),
    .E        (E),
    .req      (req),
    .clr      (clr),
    .bus      (bus_fp),
    .pending  (pending_fp),
    .overflow (overflow_fp)
  );

  encoder83_pending #(.RR(1'b1)) dut_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .E        (E),
    .req      (req),
    .clr      (clr),
    .bus      (bus_rr),
    .pending  (pending_rr),
    .overflow (overflow_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    E = 1'b0; req = 8'h00; clr = 1'b0;
    bus_fp.ready = 1'b0;
    bus_rr.ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pending_fp !== 8'h00) begin bad++; $display("FAIL reset_pending_fp got=%0h exp=00", pending_fp); end
    total++; if (bus_fp.valid !== 1'b0) begin bad++; $display("FAIL reset_valid_fp got=%0b exp=0", bus_fp.valid); end
    total++; if (bus_fp.code !== 3'd0) begin bad++; $display("FAIL reset_code_fp got=%0d exp=0", bus_fp.code); end
    total++; if (overflow_fp !== 1'b0) begin bad++; $display("FAIL reset_overflow_fp got=%0b exp=0", overflow_fp); end
    total++; if (pending_rr !== 8'h00) begin bad++; $display("FAIL reset_pending_rr got=%0h exp=00", pending_rr); end
    total++; if (bus_rr.valid !== 1'b0) begin bad++; $display("FAIL reset_valid_rr got=%0b exp=0", bus_rr.valid); end
  endtask

  task automatic test_single();
    do_reset();
    E = 1'b1; req = 8'h04;
    step();
    req = 8'h00;
    total++; if (pending_fp !== 8'h04) begin bad++; $display("FAIL single_pending got=%0h exp=04", pending_fp); end
    total++; if (bus_fp.valid !== 1'b0) begin bad++; $display("FAIL single_valid_early got=%0b exp=0", bus_fp.valid); end
    step();
    total++; if (bus_fp.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", bus_fp.valid); end
    total++; if (bus_fp.code !== 3'd2) begin bad++; $display("FAIL single_code got=%0d exp=2", bus_fp.code); end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (bus_fp.valid !== 1'b1 || bus_fp.code !== 3'd2 || pending_fp !== 8'h04) begin
        bad++;
        $display("FAIL single_hold[%0d] got valid=%0b code=%0d pending=%0h exp 1/2/04",
                 k, bus_fp.valid, bus_fp.code, pending_fp);
      end
    end
    bus_fp.ready = 1'b1;
    step();
    bus_fp.ready = 1'b0;
    total++; if (pending_fp !== 8'h00) begin bad++; $display("FAIL single_acc_pending got=%0h exp=00", pending_fp); end
    total++; if (bus_fp.valid !== 1'b0) begin bad++; $display("FAIL single_acc_valid got=%0b exp=0", bus_fp.valid); end
  endtask

  task automatic test_fixed_priority();
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd7; exp_codes[1] = 3'd4; exp_codes[2] = 3'd0;
    do_reset();
    E = 1'b1; bus_fp.ready = 1'b1; req = 8'h91;
    step();
    req = 8'h00;
    total++; if (pending_fp !== 8'h91) begin bad++; $display("FAIL fp_pending got=%0h exp=91", pending_fp); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (bus_fp.valid !== 1'b1 || bus_fp.code !== exp_codes[k]) begin
        bad++;
        $display("FAIL fp_seq[%0d] got valid=%0b code=%0d exp valid=1 code=%0d",
                 k, bus_fp.valid, bus_fp.code, exp_codes[k]);
      end
    end
    step();
    total++; if (bus_fp.valid !== 1'b0) begin bad++; $display("FAIL fp_drain got=%0b exp=0", bus_fp.valid); end
    bus_fp.ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_a [3];
    logic [2:0] exp_b [2];
    exp_a[0] = 3'd0; exp_a[1] = 3'd4; exp_a[2] = 3'd7;
    exp_b[0] = 3'd0; exp_b[1] = 3'd7;
    do_reset();
    E = 1'b1; bus_rr.ready = 1'b1; req = 8'h91;
    step();
    req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (bus_rr.valid !== 1'b1 || bus_rr.code !== exp_a[k]) begin
        bad++;
        $display("FAIL rr_seq_a[%0d] got valid=%0b code=%0d exp valid=1 code=%0d",
                 k, bus_rr.valid, bus_rr.code, exp_a[k]);
      end
    end
    step();
    total++; if (bus_rr.valid !== 1'b0) begin bad++; $display("FAIL rr_drain_a got=%0b exp=0", bus_rr.valid); end
    req = 8'h81;
    step();
    req = 8'h00;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (bus_rr.valid !== 1'b1 || bus_rr.code !== exp_b[k]) begin
        bad++;
        $display("FAIL rr_seq_b[%0d] got valid=%0b code=%0d exp valid=1 code=%0d",
                 k, bus_rr.valid, bus_rr.code, exp_b[k]);
      end
    end
    step();
    total++; if (bus_rr.valid !== 1'b0) begin bad++; $display("FAIL rr_drain_b got=%0b exp=0", bus_rr.valid); end
    bus_rr.ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    E = 1'b1; req = 8'h02;
    step();
    total++; if (overflow_fp !== 1'b0) begin bad++; $display("FAIL ov_first got=%0b exp=0", overflow_fp); end
    step();
    req = 8'h00;
    total++; if (overflow_fp !== 1'b1) begin bad++; $display("FAIL ov_second got=%0b exp=1", overflow_fp); end
    total++; if (pending_fp !== 8'h02) begin bad++; $display("FAIL ov_merge_pending got=%0h exp=02", pending_fp); end
    step();
    total++; if (overflow_fp !== 1'b0) begin bad++; $display("FAIL ov_pulse_end got=%0b exp=0", overflow_fp); end
    total++; if (bus_fp.valid !== 1'b1 || bus_fp.code !== 3'd1) begin bad++; $display("FAIL ov_code got valid=%0b code=%0d exp 1/1", bus_fp.valid, bus_fp.code); end
    // Accept code 1 while req[1] fires again in the same cycle.
    bus_fp.ready = 1'b1; req = 8'h02;
    step();
    req = 8'h00; bus_fp.ready = 1'b0;
    total++; if (overflow_fp !== 1'b0) begin bad++; $display("FAIL ov_acc_same got=%0b exp=0", overflow_fp); end
    total++; if (pending_fp !== 8'h02) begin bad++; $display("FAIL ov_acc_pending got=%0h exp=02", pending_fp); end
    total++; if (bus_fp.valid !== 1'b0) begin bad++; $display("FAIL ov_acc_valid got=%0b exp=0", bus_fp.valid); end
    step();
    total++; if (bus_fp.valid !== 1'b1 || bus_fp.code !== 3'd1) begin bad++; $display("FAIL ov_reissue got valid=%0b code=%0d exp 1/1", bus_fp.valid, bus_fp.code); end
    bus_fp.ready = 1'b1;
    step();
    bus_fp.ready = 1'b0;
    total++; if (bus_fp.valid !== 1'b0 || pending_fp !== 8'h00) begin bad++; $display("FAIL ov_final got valid=%0b pending=%0h exp 0/00", bus_fp.valid, pending_fp); end
  endtask

  task automatic test_enable();
    do_reset();
    E = 1'b0; req = 8'h30;
    step();
    req = 8'h00;
    total++; if (pending_fp !== 8'h30) begin bad++; $display("FAIL en_pending got=%0h exp=30", pending_fp); end
    step();
    step();
    total++; if (bus_fp.valid !== 1'b0) begin bad++; $display("FAIL en_blocked got=%0b exp=0", bus_fp.valid); end
    E = 1'b1;
    step();
    total++; if (bus_fp.valid !== 1'b1 || bus_fp.code !== 3'd5) begin bad++; $display("FAIL en_release got valid=%0b code=%0d exp 1/5", bus_fp.valid, bus_fp.code); end
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    E = 1'b1; req = 8'h10;
    step();
    req = 8'h00;
    step();
    total++; if (bus_fp.valid !== 1'b1 || bus_fp.code !== 3'd4) begin bad++; $display("FAIL clr_setup got valid=%0b code=%0d exp 1/4", bus_fp.valid, bus_fp.code); end
    clr = 1'b1; req = 8'hFF; bus_fp.ready = 1'b1;
    step();
    clr = 1'b0; req = 8'h00; bus_fp.ready = 1'b0;
    total++;
    if (pending_fp !== 8'h00 || bus_fp.valid !== 1'b0 || overflow_fp !== 1'b0 || bus_fp.code !== 3'd0) begin
      bad++;
      $display("FAIL clr_all got pending=%0h valid=%0b overflow=%0b code=%0d exp 00/0/0/0",
               pending_fp, bus_fp.valid, overflow_fp, bus_fp.code);
    end
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    total++; if (bus_fp.valid !== 1'b1 || bus_fp.code !== 3'd3) begin bad++; $display("FAIL arst_setup got valid=%0b code=%0d exp 1/3", bus_fp.valid, bus_fp.code); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus_fp.valid !== 1'b0 || pending_fp !== 8'h00 || bus_fp.code !== 3'd0) begin
      bad++;
      $display("FAIL arst_async got valid=%0b pending=%0h code=%0d exp 0/00/0",
               bus_fp.valid, pending_fp, bus_fp.code);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    E = 1'b0; req = 8'h00; clr = 1'b0;
    bus_fp.ready = 1'b0;
    bus_rr.ready = 1'b0;
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_overflow();
    test_enable();
    test_clear_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
